uart_tx_buffer: RTL and testbench

- Write-side buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from a host at up to one per clock into a synchronous FIFO.
- Drains the FIFO into the transmitter one word at a time using the transmitter's single-cycle valid pulse and busy handshake.
- Lets software/cores queue a message without polling transmitter busy per byte.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_buffer_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_buffer.sv | 77 +++++++
 tb/tb_uart_tx_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART buffer blocks.
// Drain FSM encoding and FIFO count width.
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'b0001,
        LAUNCH     = 4'b0010,
        WAIT_START = 4'b0100,
        WAIT_DONE  = 4'b1000
    } drain_state_t;

    localparam int TX_DEPTH = 16;
    localparam int TX_CNT_W = $clog2(TX_DEPTH + 1);

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count flags.
// Shared between the TX buffer and the future RX buffer.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;
    logic [CW-1:0]         count_next;

    // Full/empty are judged on the current flags, so a push into a
    // full FIFO is refused even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Write-side byte queue feeding the UART transmitter.
// Drains one word per transmitter busy cycle via a launch pulse.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_wr_en,
    input  logic [DATA_BITS-1:0]    i_wr_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [cnt_w(DEPTH)-1:0] o_count,
    output logic                    o_overflow,
    output logic                    o_data_valid,
    output logic [DATA_BITS-1:0]    o_data,
    input  logic                    i_busy,
    output logic                    o_idle
);

    drain_state_t         state;
    drain_state_t         state_next;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    sync_fifo #(
        .DATA_WIDTH (DATA_BITS),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (i_wr_en),
        .pop   (pop),
        .din   (i_wr_data),
        .dout  (head),
        .full  (o_full),
        .empty (o_empty),
        .count (o_count)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!o_empty && !i_busy) begin
                    state_next = LAUNCH;
                    pop        = 1'b1;
                end
            end
            LAUNCH:     state_next = WAIT_START;
            WAIT_START: if (i_busy) state_next = WAIT_DONE;
            WAIT_DONE:  if (!i_busy) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // o_data is only reloaded on a launch so it stays stable for the
    // whole transmission.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_next;
            o_overflow <= i_wr_en && o_full;
            if (pop) o_data <= head;
        end
    end

    assign o_data_valid = (state == LAUNCH);
    assign o_idle       = o_empty && (state == IDLE);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer with a busy-timer transmitter model.
// Directed vectors push expected launches; a negedge monitor checks them.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic       i_busy;
    logic       o_idle;

    logic       force_busy = 1'b0;
    int         busy_len = 10;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_launch = 0;
    int         max_cnt = 0;
    int         exp_launch_cyc = -1;
    int         snap;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] e_byte;

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DATA_BITS (8),
        .DEPTH     (16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_wr_en      (i_wr_en),
        .i_wr_data    (i_wr_data),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .i_busy       (i_busy),
        .o_idle       (o_idle)
    );

    // Transmitter model: busy from the cycle after launch for busy_len cycles
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) busy_cnt <= 0;
        else if (o_data_valid) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign i_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
        if (o_data_valid) begin
            n_launch++;
            chk("pulse_width", int'(prev_valid), 0);
            chk("busy_guard", int'(i_busy), 0);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_launch: got 0x%0h expected none", o_data);
            end else begin
                e_byte = exp_q.pop_front();
                chk("launch_data", int'(o_data), int'(e_byte));
            end
            if (exp_launch_cyc >= 0) begin
                chk("latency", cyc, exp_launch_cyc);
                exp_launch_cyc = -1;
            end
        end
        prev_valid = o_data_valid;
    end

    task automatic wr(input logic [7:0] d, input bit expect_it);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        if (expect_it) exp_q.push_back(d);
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (!(o_idle && !i_busy && exp_q.size() == 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(o_idle && !i_busy && exp_q.size() == 0), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_full", int'(o_full), 0);
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_count", int'(o_count), 0);
        chk("rst_overflow", int'(o_overflow), 0);
        chk("rst_valid", int'(o_data_valid), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_idle", int'(o_idle), 1);
        n_rst = 1'b1;
        @(negedge clk);

        // Single byte with latency check
        busy_len = 10;
        exp_launch_cyc = cyc + 2;
        wr(8'hA5, 1'b1);
        chk("single_empty_deassert", int'(o_empty), 0);
        wait_idle("single_idle", 40);

        // Burst of five against a slow transmitter
        busy_len = 20;
        for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
        wait_idle("burst_drain", 300);

        // Fill with transmitter held busy, then overflow
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1'b1);
        chk("fill_full", int'(o_full), 1);
        chk("fill_count", int'(o_count), 16);
        chk("fill_empty", int'(o_empty), 0);
        wr(8'hEE, 1'b0);
        chk("ovf_pulse", int'(o_overflow), 1);
        chk("ovf_count", int'(o_count), 16);
        @(negedge clk);
        chk("ovf_clear", int'(o_overflow), 0);

        // Write in the same cycle the pop happens while full
        force_busy = 1'b0;
        i_wr_en    = 1'b1;
        i_wr_data  = 8'hDD;
        @(negedge clk);
        i_wr_en = 1'b0;
        chk("coll_ovf", int'(o_overflow), 1);
        chk("coll_count", int'(o_count), 15);
        chk("coll_valid", int'(o_data_valid), 1);
        busy_len = 3;
        wait_idle("fill_drain", 400);

        // Pointer wrap with interleaved writes and drains
        busy_len = 2;
        max_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            int k = 0;
            while (o_full && k < 100) begin
                @(negedge clk);
                k++;
            end
            wr(8'(8'h40 + i), 1'b1);
            if (i % 4 == 3) repeat (3) @(negedge clk);
        end
        wait_idle("wrap_drain", 600);
        chk("wrap_max_count", int'(max_cnt <= 16), 1);

        // Reset while eight words are queued and the FSM waits on busy
        busy_len = 50;
        for (int i = 0; i < 9; i++) wr(8'(8'h80 + i), i == 0);
        chk("pre_rst_count", int'(o_count), 8);
        chk("pre_rst_busy", int'(i_busy), 1);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_count", int'(o_count), 0);
        chk("mid_rst_empty", int'(o_empty), 1);
        chk("mid_rst_valid", int'(o_data_valid), 0);
        chk("mid_rst_idle", int'(o_idle), 1);
        @(negedge clk);
        n_rst = 1'b1;
        snap = n_launch;
        repeat (10) @(negedge clk);
        chk("post_rst_no_launch", n_launch, snap);
        chk("post_rst_idle", int'(o_idle), 1);
        busy_len = 4;
        wr(8'h77, 1'b1);
        wait_idle("post_rst_drain", 40);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
